// File: rtl/sine_table_loader.sv
// -----------------------------------------------------------------------------
// sine_table_loader
//
// Loads the waveform-stage sine table from a byte stream. Each pair of
// accepted bytes forms one 16-bit word, written to consecutive addresses
// starting at 0. A full load is WORD_COUNT writes, after which the loader
// parks in DONE until the next start request.
//
// Parameters
//   WORD_COUNT  number of 16-bit entries per load (1..16384)
//   BIG_ENDIAN  0: first byte of a word is the low byte; 1: it is the high byte
//
// Ports
//   i_Clock                  clock, rising-edge active
//   i_Reset                  asynchronous active-high reset
//   i_Start                  one-cycle request to (re)start a load at address 0
//   i_ByteValid / i_Byte     byte stream; a byte moves when o_ByteReady is high
//   o_ByteReady              loader can take i_Byte this cycle
//   o_SineTableWriteEnable   one-cycle write strobe to the table
//   o_SineTableWriteAddress  table write address (holds last written value)
//   o_SineTableWriteValue    table write data, bit 15 always 0 (holds last value)
//   o_Busy                   load in progress; table contents are in flux
//   o_Done                   last load completed all WORD_COUNT writes
//   o_FormatError            sticky; a received word had bit 15 set
// -----------------------------------------------------------------------------
module sine_table_loader #(
  parameter int WORD_COUNT = 16384,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Start,
  input  logic        i_ByteValid,
  input  logic [7:0]  i_Byte,
  output logic        o_ByteReady,
  output logic        o_SineTableWriteEnable,
  output logic [13:0] o_SineTableWriteAddress,
  output logic [15:0] o_SineTableWriteValue,
  output logic        o_Busy,
  output logic        o_Done,
  output logic        o_FormatError
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BYTE0,
    S_BYTE1,
    S_WRITE,
    S_DONE
  } state_e;

  localparam logic [13:0] LAST_ADDR = 14'(WORD_COUNT - 1);

  state_e      state_q, state_d;
  logic [13:0] addr_cnt_q, addr_cnt_d;      // address of the word being assembled
  logic [7:0]  byte_q, byte_d;              // first byte of the current word
  logic [13:0] wr_addr_q, wr_addr_d;        // last written address (output)
  logic [15:0] wr_value_q, wr_value_d;      // last written value (output)
  logic        format_error_q, format_error_d;

  logic        accept;
  logic [15:0] word;

  assign accept = o_ByteReady & i_ByteValid;
  assign word   = BIG_ENDIAN ? {byte_q, i_Byte} : {i_Byte, byte_q};

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q        <= S_IDLE;
      addr_cnt_q     <= '0;
      byte_q         <= '0;
      wr_addr_q      <= '0;
      wr_value_q     <= '0;
      format_error_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_cnt_q     <= addr_cnt_d;
      byte_q         <= byte_d;
      wr_addr_q      <= wr_addr_d;
      wr_value_q     <= wr_value_d;
      format_error_q <= format_error_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output is given a default before the case
  // statement so no path leaves it unassigned and a latch is never inferred.
  always_comb begin
    state_d = state_q;
    if (i_Start) begin
      state_d = S_BYTE0;
    end else begin
      unique case (state_q)
        S_BYTE0: if (accept) state_d = S_BYTE1;
        S_BYTE1: if (accept) state_d = S_WRITE;
        S_WRITE: state_d = (addr_cnt_q == LAST_ADDR) ? S_DONE : S_BYTE0;
        default: state_d = state_q;   // IDLE and DONE wait for i_Start
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    addr_cnt_d     = addr_cnt_q;
    byte_d         = byte_q;
    wr_addr_d      = wr_addr_q;
    wr_value_d     = wr_value_q;
    format_error_d = format_error_q;
    if (i_Start) begin
      // Write outputs keep the last written entry; only the load state restarts.
      addr_cnt_d     = '0;
      byte_d         = '0;
      format_error_d = 1'b0;
    end else begin
      unique case (state_q)
        S_BYTE0: if (accept) byte_d = i_Byte;
        S_BYTE1: begin
          if (accept) begin
            // Output registers update on entry to WRITE so address and value
            // are valid in the same cycle as the strobe.
            wr_addr_d      = addr_cnt_q;
            wr_value_d     = {1'b0, word[14:0]};
            format_error_d = format_error_q | word[15];
          end
        end
        S_WRITE: begin
          // The counter stops on the last entry rather than wrapping.
          if (addr_cnt_q != LAST_ADDR) addr_cnt_d = addr_cnt_q + 14'd1;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // All outputs derive from asynchronously reset flops, so reset clears them
  // (including the write strobe) without waiting for a clock edge.
  always_comb begin
    o_ByteReady             = ((state_q == S_BYTE0) || (state_q == S_BYTE1)) && !i_Start;
    o_SineTableWriteEnable  = (state_q == S_WRITE);
    o_Busy                  = (state_q == S_BYTE0) || (state_q == S_BYTE1) ||
                              (state_q == S_WRITE);
    o_Done                  = (state_q == S_DONE);
    o_FormatError           = format_error_q;
    o_SineTableWriteAddress = wr_addr_q;
    o_SineTableWriteValue   = wr_value_q;
  end

endmodule

// File: doc/sine_table_loader.md
SINE_TABLE_LOADER -- requirements
Module: sine_table_loader

Interface
- REQ-001: Parameter WORD_COUNT, default 16384, number of 16-bit table entries loaded per sequence; legal range 1..16384.
- REQ-002: Parameter BIG_ENDIAN, default 0; 0 = first byte of each word is the low byte, 1 = first byte is the high byte.
- REQ-003: One clock; reset is asynchronous and active-high.
- REQ-004: i_Clock  input  1  clock; all state changes on its rising edge.
- REQ-005: i_Reset  input  1  asynchronous, active-high reset.
- REQ-006: i_Start  input  1  single-cycle request to begin (or restart) a load at address 0.
- REQ-007: i_ByteValid  input  1  i_Byte holds a valid byte this cycle.
- REQ-008: i_Byte  input  8  next byte of the table stream.
- REQ-009: o_ByteReady  output  1  loader accepts i_Byte this cycle.
- REQ-010: o_SineTableWriteEnable  output  1  one-cycle write strobe to the waveform stage sine table.
- REQ-011: o_SineTableWriteAddress  output  14  table write address.
- REQ-012: o_SineTableWriteValue  output  16  table write data.
- REQ-013: o_Busy  output  1  load in progress; the synth pipeline must not rely on table reads while high.
- REQ-014: o_Done  output  1  sticky; the last load completed all WORD_COUNT writes.
- REQ-015: o_FormatError  output  1  sticky; a received word had bit 15 set.

Function
- REQ-016: FSM states IDLE, BYTE0, BYTE1, WRITE, DONE.
- REQ-017: A byte is accepted only in a cycle where i_ByteValid and o_ByteReady are both high.
- REQ-018: o_ByteReady is high only in BYTE0 or BYTE1, and only while i_Start is low.
- REQ-019: i_Start high in any state: next state BYTE0, address counter 0, partial byte discarded, o_Done and o_FormatError cleared, write enable low next cycle.
- REQ-020: BYTE0 -> BYTE1 on accept, storing the byte as low byte (BIG_ENDIAN=0) or high byte (BIG_ENDIAN=1).
- REQ-021: BYTE1 -> WRITE on accept, completing the word.
- REQ-022: In WRITE, o_SineTableWriteEnable is high for exactly one cycle, with address and value valid in that same cycle.
- REQ-023: Latency: BYTE1 accept in cycle N produces the write strobe in cycle N+1.
- REQ-024: Maximum throughput is one word per 3 cycles.
- REQ-025: o_SineTableWriteValue[15] is forced to 0 and [14:0] carries the received bits; a received bit 15 of 1 sets o_FormatError and the write still occurs.
- REQ-026: After WRITE the address increments by 1 and the FSM goes to BYTE0; if the written address was WORD_COUNT-1 it goes to DONE instead, and the address does not wrap.
- REQ-027: In DONE: o_Done high, o_Busy low, bytes not accepted; DONE is left only via i_Start.
- REQ-028: o_Busy is high in BYTE0, BYTE1 and WRITE, and low in IDLE and DONE.
- REQ-029: o_SineTableWriteAddress and o_SineTableWriteValue hold their last written values outside WRITE.
- REQ-030: i_ByteValid in IDLE or DONE is ignored, with no state change.
- REQ-031: A stalled stream (i_ByteValid low) holds the state indefinitely, with no timeout.

Reset
- REQ-032: While i_Reset is high: state IDLE; all outputs 0, including o_ByteReady, o_SineTableWriteEnable, address, value, o_Busy, o_Done and o_FormatError; the byte register is cleared.
- REQ-033: Reset asserted mid-load aborts the load immediately and asynchronously, and the write strobe drops without waiting for a clock.
- REQ-034: After reset deassertion, the loader stays in IDLE until i_Start.

Verification
- REQ-035: Directed scenario, full load with BIG_ENDIAN=0: after i_Start, stream 32768 bytes forming value = address & 0x7FFF. Required response: 16384 strobes, address 0..16383 in order, o_Done=1 and o_Busy=0 one cycle after the last strobe, no further strobes.
- REQ-036: Directed scenario, byte order: BIG_ENDIAN=0 and bytes 0x34,0x12 -> value 0x1234 at address 0; BIG_ENDIAN=1 and the same bytes -> 0x3412.
- REQ-037: Directed scenario, format error: word 0xFFFF at address 5 -> written value 0x7FFF at address 5, o_FormatError=1 and remaining high through DONE; a new i_Start clears it.
- REQ-038: Directed scenario, restart: i_Start after 3 words plus 1 byte -> partial byte discarded, next strobe at address 0 carrying the next two stream bytes.
- REQ-039: Directed scenario, async reset in WRITE: all outputs 0 before the next clock edge; a later byte with i_ByteValid=1 is not accepted until i_Start.
- REQ-040: Directed scenario, WORD_COUNT=4 with continuous valid bytes: exactly 4 strobes 3 cycles apart at addresses 0..3; extra bytes see o_ByteReady=0; i_Start together with i_ByteValid is not accepted that cycle.
